av_operand_feeder: RTL and testbench
====================================

// Module: av_operand_feeder
// PURPOSE
//  Initiator/sequencer for the token-wise mixed-precision A*V multiplier.
//  For each token k = 0..NUM_TOKENS-1 it does four things: fetch column k of A from BRAM,
//  fetch row k of V from BRAM, present both with that token's precision code, then pulse mul_start and wait for mul_done.
//  The multiplier accumulates across tokens, so A*V is complete after the last mul_done.
// PARAMETERS
//  A_ROWS      8   rows of A = length of the presented A column
//  V_COLS      32  columns of V = length of the presented V row; must be >= A_ROWS
//  NUM_TOKENS  8   tokens (columns of A / rows of V)
//  WIDTH       16  element width (Q1.15)
//  ADDR_W      8   BRAM address width; holds A_ROWS*NUM_TOKENS-1 and NUM_TOKENS*V_COLS-1
// PORTS
//  clk               in   1               clock
//  rst               in   1               synchronous active-high reset
//  start             in   1               begin a full A*V pass (sampled in IDLE only)
//  token_prec        in   2*NUM_TOKENS    precision per token: [2k+1:2k], 00 INT4 / 01 INT8 / 10 FP16 / 11 invalid
//  busy              out  1               high in every state except IDLE
//  done              out  1               one-cycle pulse after the last token completes
//  a_rd_en           out  1               A BRAM read strobe
//  a_rd_addr         out  ADDR_W          A address = row*NUM_TOKENS + k (row-major)
//  a_rd_data         in   WIDTH           A data, valid 1 cycle after a_rd_en
//  v_rd_en           out  1               V BRAM read strobe
//  v_rd_addr         out  ADDR_W          V address = k*V_COLS + col (row-major)
//  v_rd_data         in   WIDTH           V data, valid 1 cycle after v_rd_en
//  mul_start         out  1               one-cycle start pulse to the multiplier
//  mul_precision_sel out  2               precision of the current token
//  mul_a_col         out  WIDTH*A_ROWS    A column k (element r in slice r)
//  mul_v_row         out  WIDTH*V_COLS    V row k (element c in slice c)
//  mul_done          in   1               multiplier completion pulse
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): enter IDLE and clear k, idx, every output and the operand registers to 0.
//   Reset wins over every other input and is legal in any state; it abandons the pass and does not pulse done.
//  State machine:
//   IDLE  -> FETCH when start=1; k <= 0, idx <= 0.
//   FETCH: one read per cycle for idx = 0..V_COLS-1.
//    V side: v_rd_en=1 with v_rd_addr = k*V_COLS+idx.
//    A side: a_rd_en=1 only while idx < A_ROWS, with a_rd_addr = idx*NUM_TOKENS+k.
//    After idx = V_COLS-1 the next state is DRAIN.
//   DRAIN: one cycle in which the last returned data is captured.
//    Return data is written to operand slice idx-1, one cycle after its read.
//    DRAIN -> ISSUE.
//   ISSUE: mul_start=1 for exactly 1 cycle. ISSUE -> WAIT.
//   WAIT: hold all mul_* operands stable.
//    On mul_done: if k==NUM_TOKENS-1 go to DONE; otherwise k <= k+1, idx <= 0 and go to FETCH.
//   DONE: done=1 for 1 cycle. DONE -> IDLE.
//  Registered-output rules:
//   mul_precision_sel is registered in ISSUE from token_prec[k].
//   Code 11 is forwarded as 10 (FP16).
//   mul_precision_sel, mul_a_col and mul_v_row change only in FETCH/DRAIN/ISSUE; they are stable throughout WAIT.
//  Latency:
//   If start is sampled at edge t, mul_start is high in cycle t+V_COLS+2.
//   Each token costs V_COLS+2 cycles plus the multiplier's own time.
//  Ignored inputs:
//   start while busy=1 is ignored (no restart, no queueing).
//   mul_done outside WAIT is ignored.
//   mul_done in the same cycle as mul_start (ISSUE) is ignored.
//  Protocol checks:
//   a_rd_en/v_rd_en are 0 outside FETCH.
//   Addresses never exceed the A or V matrix extents.
//  Timing: the token_prec sample point is ISSUE, so token_prec may change freely except in that cycle.
// TESTING
//  T1 single pass:
//   Stimulus: defaults, all tokens FP16, A[r][k]=16*r+k, V[k][c]=64*k+c, model returns mul_done 6 cycles after mul_start.
//   Expect: 8 mul_start pulses; in WAIT for token k, mul_a_col[r]=16r+k and mul_v_row[c]=64k+c; done 1 cycle after the 8th mul_done.
//  T2 latency:
//   Stimulus: start at cycle 0.
//   Expect: first a_rd_en/v_rd_en in cycle 1; a_rd_en deasserts after 8 cycles; v_rd_en deasserts after 32 cycles; mul_start in cycle 34.
//  T3 precision:
//   Stimulus: token_prec per token = 00,01,10,11,00,01,10,11.
//   Expect: mul_precision_sel = 00,01,10,10,00,01,10,10.
//  T4 ignored inputs:
//   Stimulus: start re-pulsed in FETCH and WAIT; spurious mul_done in FETCH and ISSUE.
//   Expect: no extra mul_start, token order unchanged, exactly one done.
//  T5 reset mid-op:
//   Stimulus: rst=1 for 1 cycle during WAIT of token 3.
//   Expect: next cycle busy=0 and all outputs 0; a new start fetches token 0 (v_rd_addr=0).
//  T6 back-to-back:
//   Stimulus: start asserted in the cycle after done.
//   Expect: a second full pass with identical operand sequence.

Source files
------------

// File: rtl/av_operand_feeder.sv
// rtl/av_operand_feeder.sv - per-token A-column / V-row fetch and A*V multiplier sequencing
module av_operand_feeder #(
  parameter int A_ROWS     = 8,
  parameter int V_COLS     = 32,
  parameter int NUM_TOKENS = 8,
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [2*NUM_TOKENS-1:0]   token_prec_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      a_rd_en_o,
  output logic [ADDR_W-1:0]         a_rd_addr_o,
  input  logic [WIDTH-1:0]          a_rd_data_i,
  output logic                      v_rd_en_o,
  output logic [ADDR_W-1:0]         v_rd_addr_o,
  input  logic [WIDTH-1:0]          v_rd_data_i,
  output logic                      mul_start_o,
  output logic [1:0]                mul_precision_sel_o,
  output logic [WIDTH*A_ROWS-1:0]   mul_a_col_o,
  output logic [WIDTH*V_COLS-1:0]   mul_v_row_o,
  input  logic                      mul_done_i
);
  localparam int IDX_W = $clog2(V_COLS + 1);
  localparam int K_W   = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [1:0]       prec_q;
  logic [1:0]       prec_raw;
  logic [WIDTH-1:0] a_col_q [A_ROWS];
  logic [WIDTH-1:0] v_row_q [V_COLS];
  logic             cap_en;
  logic [IDX_W-1:0] cap_idx;

  assign prec_raw = token_prec_i[2*k_q +: 2];
  // BRAM data lags its read by one cycle, so it lands in slice idx-1; DRAIN catches the last one.
  assign cap_en   = ((state_q == S_FETCH) && (idx_q != '0)) || (state_q == S_DRAIN);
  assign cap_idx  = idx_q - IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    a_rd_en_o   = 1'b0;
    a_rd_addr_o = '0;
    v_rd_en_o   = 1'b0;
    v_rd_addr_o = '0;
    mul_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
          k_d     = '0;
        end
      end
      S_FETCH: begin
        v_rd_en_o   = 1'b1;
        v_rd_addr_o = ADDR_W'(k_q) * ADDR_W'(V_COLS) + ADDR_W'(idx_q);
        if (idx_q < IDX_W'(A_ROWS)) begin
          a_rd_en_o   = 1'b1;
          a_rd_addr_o = ADDR_W'(idx_q) * ADDR_W'(NUM_TOKENS) + ADDR_W'(k_q);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(V_COLS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_ISSUE;
      S_ISSUE: begin
        mul_start_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done_i) begin
          if (k_q == K_W'(NUM_TOKENS - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + K_W'(1);
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      k_q     <= '0;
      prec_q  <= 2'b00;
      for (int r = 0; r < A_ROWS; r++) a_col_q[r] <= '0;
      for (int c = 0; c < V_COLS; c++) v_row_q[c] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      // The multiplier has no path for code 11, so it runs as FP16.
      if (state_q == S_ISSUE) prec_q <= (prec_raw == 2'b11) ? 2'b10 : prec_raw;
      for (int r = 0; r < A_ROWS; r++)
        if (cap_en && (cap_idx == IDX_W'(r))) a_col_q[r] <= a_rd_data_i;
      for (int c = 0; c < V_COLS; c++)
        if (cap_en && (cap_idx == IDX_W'(c))) v_row_q[c] <= v_rd_data_i;
    end
  end

  assign mul_precision_sel_o = prec_q;

  for (genvar r = 0; r < A_ROWS; r++) begin : g_a_col
    assign mul_a_col_o[r*WIDTH +: WIDTH] = a_col_q[r];
  end
  for (genvar c = 0; c < V_COLS; c++) begin : g_v_row
    assign mul_v_row_o[c*WIDTH +: WIDTH] = v_row_q[c];
  end

endmodule

// File: tb/tb_av_operand_feeder.sv
// tb/tb_av_operand_feeder.sv - randomized self-checking bench for av_operand_feeder
module tb_av_operand_feeder;
  localparam int AR = 8;
  localparam int VC = 32;
  localparam int NT = 8;
  localparam int W  = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2*NT-1:0] token_prec = '0;
  logic            busy, done, a_rd_en, v_rd_en, mul_start;
  logic [AW-1:0]   a_rd_addr, v_rd_addr;
  logic [W-1:0]    a_rd_data = '0;
  logic [W-1:0]    v_rd_data = '0;
  logic [1:0]      mul_precision_sel;
  logic [W*AR-1:0] mul_a_col;
  logic [W*VC-1:0] mul_v_row;
  logic            mul_done_m = 1'b0;
  logic            mul_done_spur = 1'b0;
  logic            mul_done;

  logic [W-1:0] a_mem [256];
  logic [W-1:0] v_mem [256];

  int checks = 0;
  int errors = 0;
  int mul_dly = 6;
  int mul_cnt = 0;

  assign mul_done = mul_done_m | mul_done_spur;

  always #5 clk = ~clk;

  av_operand_feeder #(.A_ROWS(AR), .V_COLS(VC), .NUM_TOKENS(NT), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .token_prec_i(token_prec),
    .busy_o(busy), .done_o(done),
    .a_rd_en_o(a_rd_en), .a_rd_addr_o(a_rd_addr), .a_rd_data_i(a_rd_data),
    .v_rd_en_o(v_rd_en), .v_rd_addr_o(v_rd_addr), .v_rd_data_i(v_rd_data),
    .mul_start_o(mul_start), .mul_precision_sel_o(mul_precision_sel),
    .mul_a_col_o(mul_a_col), .mul_v_row_o(mul_v_row), .mul_done_i(mul_done)
  );

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (v_rd_en) v_rd_data <= v_mem[v_rd_addr];
  end

  // Multiplier stand-in: mul_done arrives mul_dly cycles after the mul_start cycle.
  always @(posedge clk) begin
    mul_done_m <= 1'b0;
    if (rst) mul_cnt <= 0;
    else if (mul_start) mul_cnt <= mul_dly - 1;
    else if (mul_cnt != 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1) mul_done_m <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] prec_map(input logic [1:0] code);
    return (code == 2'b11) ? 2'b10 : code;
  endfunction

  // Reference: phase 0 idle, 1 reads+drain+issue (m_t counts cycles), 2 waiting, 3 done.
  int          m_phase = 0;
  int          m_t = 0;
  int          m_k = 0;
  int          m_passes = 0;
  int          obs_done = 0;
  bit          m_live = 0;
  bit          m_after_rst = 0;
  logic [1:0]  m_prec = 2'b00;

  initial begin
    logic [W*AR-1:0] ea;
    logic [W*VC-1:0] ev;
    logic [1:0]      ep;
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("busy", 512'(busy), 512'(m_phase != 0));
        check("done", 512'(done), 512'(m_phase == 3));
        check("mul_start", 512'(mul_start), 512'(m_phase == 1 && m_t == VC + 1));
        check("v_rd_en", 512'(v_rd_en), 512'(m_phase == 1 && m_t < VC));
        check("a_rd_en", 512'(a_rd_en), 512'(m_phase == 1 && m_t < AR));
        if (m_phase == 1 && m_t < VC) check("v_rd_addr", 512'(v_rd_addr), 512'(m_k * VC + m_t));
        if (m_phase == 1 && m_t < AR) check("a_rd_addr", 512'(a_rd_addr), 512'(m_t * NT + m_k));
        if (m_phase == 2 || (m_phase == 0 && m_after_rst)) begin
          ea = '0;
          ev = '0;
          ep = 2'b00;
          if (m_phase == 2) begin
            for (int r = 0; r < AR; r++) ea[r*W +: W] = a_mem[r*NT + m_k];
            for (int c = 0; c < VC; c++) ev[c*W +: W] = v_mem[m_k*VC + c];
            ep = m_prec;
          end
          check("mul_a_col", 512'(mul_a_col), 512'(ea));
          check("mul_v_row", 512'(mul_v_row), 512'(ev));
          check("mul_precision_sel", 512'(mul_precision_sel), 512'(ep));
        end
        if (done) obs_done++;
      end
      if (rst) begin
        m_live = 1;
        m_after_rst = 1;
        m_phase = 0;
        m_t = 0;
        m_k = 0;
      end else if (m_live) begin
        case (m_phase)
          0: if (start) begin
            m_phase = 1;
            m_t = 0;
            m_k = 0;
            m_after_rst = 0;
          end
          1: begin
            if (m_t == VC + 1) begin
              m_prec = prec_map(token_prec[2*m_k +: 2]);
              m_phase = 2;
            end else m_t++;
          end
          2: if (mul_done) begin
            if (m_k == NT - 1) begin
              m_phase = 3;
              m_passes++;
            end else begin
              m_k++;
              m_t = 0;
              m_phase = 1;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic drive_until(input int target, input bit noise, input bit churn, input int rst_tok);
    int cyc = 0;
    bit did_rst = 0;
    while (m_passes < target && cyc < 3000) begin
      start = (m_phase == 0) || (noise && ((m_phase == 1 && m_t == 5) || (m_phase == 2 && $urandom_range(3) == 0)));
      mul_done_spur = noise && (m_phase != 2) &&
                      ((m_phase == 1 && (m_t == 3 || m_t == VC + 1)) || $urandom_range(9) == 0);
      if (churn) token_prec = 16'($urandom);
      rst = (rst_tok >= 0) && !did_rst && (m_phase == 2) && (m_k == rst_tok);
      if (rst) did_rst = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    mul_done_spur = 1'b0;
    rst = 1'b0;
    if (cyc >= 3000) check("timeout", 512'(m_passes), 512'(target));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = '0;
      v_mem[i] = '0;
    end
    for (int k = 0; k < NT; k++) begin
      for (int r = 0; r < AR; r++) a_mem[r*NT + k] = W'(16*r + k);
      for (int c = 0; c < VC; c++) v_mem[k*VC + c] = W'(64*k + c);
    end
    token_prec = 16'hAAAA;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    drive_until(1, 0, 0, -1);

    token_prec = 16'hE4E4;
    mul_dly = 3;
    drive_until(2, 1, 0, -1);

    for (int i = 0; i < 256; i++) begin
      a_mem[i] = W'($urandom);
      v_mem[i] = W'($urandom);
    end
    mul_dly = 2 + int'($urandom_range(7));
    drive_until(3, 1, 1, 3);

    mul_dly = 2 + int'($urandom_range(7));
    drive_until(5, 0, 1, -1);

    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", 512'(obs_done), 512'(m_passes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
